// File: rtl/box_overlay_pkg.sv
`default_nettype none
//==============================================================================
// Module   : box_overlay_pkg
// Purpose  : Shared types, slot colour palette and RGB565 blend helper for
//            the box overlay pipeline.
// Revision : 1.0 - initial release
//==============================================================================
package box_overlay_pkg;

    // Coordinate widths carried in a slot record; the top-level H_BITS/V_BITS
    // parameters default to these so the record and the pixel counts agree.
    localparam int BOX_H_BITS = 5;
    localparam int BOX_V_BITS = 5;

    typedef struct packed {
        logic                  valid;
        logic [BOX_H_BITS-1:0] h;
        logic [BOX_V_BITS-1:0] v;
    } box_t;

    // Slot colours: red, green, blue, yellow, magenta, cyan, white, orange.
    localparam logic [15:0] PALETTE [8] = '{
        16'hF800, 16'h07E0, 16'h001F, 16'hFFE0,
        16'hF81F, 16'h07FF, 16'hFFFF, 16'hFD20
    };

    // 50% mix of two RGB565 pixels, each channel averaged at its own precision.
    function automatic logic [15:0] blend565(input logic [15:0] pix, input logic [15:0] col);
        logic [5:0] r_sum;
        logic [6:0] g_sum;
        logic [5:0] b_sum;
        r_sum = {1'b0, pix[15:11]} + {1'b0, col[15:11]};
        g_sum = {1'b0, pix[10:5]}  + {1'b0, col[10:5]};
        b_sum = {1'b0, pix[4:0]}   + {1'b0, col[4:0]};
        return {r_sum[5:1], g_sum[6:1], b_sum[5:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/box_overlay_box_hit.sv
`default_nettype none
//==============================================================================
// Module   : box_hit
// Purpose  : Combinational hit test of one pixel against one box slot.
//            Reports whether the pixel lies inside the box and whether it
//            lies on the outline ring of width THICK.
// Revision : 1.0 - initial release
//==============================================================================
module box_hit
    import box_overlay_pkg::*;
#(
    parameter int BOX_HALF = 2,
    parameter int THICK    = 1
) (
    input  box_t                  box,
    input  logic [BOX_H_BITS-1:0] h,
    input  logic [BOX_V_BITS-1:0] v,
    output logic                  in_box,
    output logic                  on_edge
);

    localparam int HW    = BOX_H_BITS + 1;
    localparam int VW    = BOX_V_BITS + 1;
    localparam int INNER = BOX_HALF - THICK;
    // A negative inner half-size means the whole box is outline.
    localparam int INNER_CLAMP = (INNER >= 0) ? INNER : 0;

    localparam logic [HW-1:0] HALF_H  = HW'(BOX_HALF);
    localparam logic [VW-1:0] HALF_V  = VW'(BOX_HALF);
    localparam logic [HW-1:0] INNER_H = HW'(INNER_CLAMP);
    localparam logic [VW-1:0] INNER_V = VW'(INNER_CLAMP);

    logic [HW-1:0] dh;
    logic [VW-1:0] dv;
    logic [HW-1:0] adh;
    logic [VW-1:0] adv;
    logic          inner;

    // Signed distance from the box centre, one bit wider so nothing wraps.
    always_comb begin
        dh      = {1'b0, h} - {1'b0, box.h};
        dv      = {1'b0, v} - {1'b0, box.v};
        adh     = dh[HW-1] ? (~dh + 1'b1) : dh;
        adv     = dv[VW-1] ? (~dv + 1'b1) : dv;
        in_box  = box.valid && (adh <= HALF_H) && (adv <= HALF_V);
        inner   = (INNER >= 0) && (adh <= INNER_H) && (adv <= INNER_V);
        on_edge = in_box && !inner;
    end

endmodule
`default_nettype wire

// File: rtl/box_overlay.sv
`default_nettype none
//==============================================================================
// Module   : box_overlay
// Purpose  : Two-stage pixel pipeline drawing up to NUM_BOXES coloured boxes
//            (outline or 50% blended fill) over an RGB565 stream. Box slots
//            are written into a shadow table, copied to the active table at
//            the last beat of each frame, and expire if not refreshed.
// Revision : 1.0 - initial release
//==============================================================================
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int H_BITS         = BOX_H_BITS,
    parameter int V_BITS         = BOX_V_BITS,
    parameter int H_COUNT        = 32,
    parameter int V_COUNT        = 24,
    parameter int NUM_BOXES      = 4,
    parameter int BOX_HALF       = 2,
    parameter int THICK          = 1,
    parameter int TIMEOUT_FRAMES = 8,
    localparam int SLOT_W        = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              box_valid_in,
    input  logic [SLOT_W-1:0] box_slot_in,
    input  logic [H_BITS-1:0] box_h_in,
    input  logic [V_BITS-1:0] box_v_in,
    input  logic              box_clear_in,
    input  logic              fill_mode_in,
    input  logic              data_valid_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic [15:0]       pixel_in,
    output logic              data_valid_out,
    output logic [H_BITS-1:0] hcount_out,
    output logic [V_BITS-1:0] vcount_out,
    output logic [15:0]       pixel_out
);

    // Age saturates at the timeout value; with no timeout a 1-bit age suffices.
    localparam int AGE_MAX = (TIMEOUT_FRAMES == 0) ? 1 : TIMEOUT_FRAMES;
    localparam int AGE_W   = $clog2(AGE_MAX + 1);

    // Slot tables
    box_t             shadow     [NUM_BOXES];
    box_t             active     [NUM_BOXES];
    logic [AGE_W-1:0] age        [NUM_BOXES];
    logic [NUM_BOXES-1:0] refresh;

    box_t             shadow_nxt [NUM_BOXES];
    box_t             shadow_cm  [NUM_BOXES];
    logic [AGE_W-1:0] age_nxt    [NUM_BOXES];
    logic [NUM_BOXES-1:0] refresh_nxt;
    logic                 commit;

    // Hit test results
    logic [NUM_BOXES-1:0] in_box_now;
    logic [NUM_BOXES-1:0] on_edge_now;
    logic [NUM_BOXES-1:0] hit_now;

    // Stage 1 registers
    logic                 valid1;
    logic [H_BITS-1:0]    h1;
    logic [V_BITS-1:0]    v1;
    logic [15:0]          pix1;
    logic                 fill1;
    logic [NUM_BOXES-1:0] hit1;

    // Stage 2 selection
    logic                 found;
    logic [2:0]           sel;
    logic [15:0]          pix_nxt;

    // The last beat of the frame swaps in the next table.
    assign commit = data_valid_in
                 && (hcount_in == H_BITS'(H_COUNT - 1))
                 && (vcount_in == V_BITS'(V_COUNT - 1));

    // Shadow update (clear before write), refresh flags and commit-time ageing.
    always_comb begin
        refresh_nxt = refresh;
        for (int i = 0; i < NUM_BOXES; i++) begin
            shadow_nxt[i] = shadow[i];
            if (box_clear_in) begin
                shadow_nxt[i].valid = 1'b0;
            end
            if (box_valid_in && (box_slot_in == SLOT_W'(i))) begin
                shadow_nxt[i]  = box_t'{valid: 1'b1, h: box_h_in, v: box_v_in};
                refresh_nxt[i] = 1'b1;
            end
            if (refresh_nxt[i]) begin
                age_nxt[i] = '0;
            end else if (age[i] == AGE_W'(AGE_MAX)) begin
                age_nxt[i] = age[i];
            end else begin
                age_nxt[i] = age[i] + 1'b1;
            end
            shadow_cm[i] = shadow_nxt[i];
            if ((TIMEOUT_FRAMES != 0) && (age_nxt[i] == AGE_W'(AGE_MAX))) begin
                shadow_cm[i].valid = 1'b0;
            end
        end
    end

    // Table registers: shadow tracks writes every cycle, active only at commit.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                age[i]    <= '0;
            end
            refresh <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                shadow[i] <= shadow_cm[i];
                active[i] <= shadow_cm[i];
                age[i]    <= age_nxt[i];
            end
            refresh <= '0;
        end else begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                shadow[i] <= shadow_nxt[i];
            end
            refresh <= refresh_nxt;
        end
    end

    generate
        for (genvar g = 0; g < NUM_BOXES; g++) begin : g_hit
            box_hit #(
                .BOX_HALF (BOX_HALF),
                .THICK    (THICK)
            ) u_box_hit (
                .box     (active[g]),
                .h       (hcount_in),
                .v       (vcount_in),
                .in_box  (in_box_now[g]),
                .on_edge (on_edge_now[g])
            );
        end
    endgenerate

    // Keep only the hit kind that matters for this beat's drawing mode.
    assign hit_now = fill_mode_in ? in_box_now : on_edge_now;

    // Stage 1: register beat, mode and per-slot hit vector.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid1 <= 1'b0;
            h1     <= '0;
            v1     <= '0;
            pix1   <= '0;
            fill1  <= 1'b0;
            hit1   <= '0;
        end else begin
            valid1 <= data_valid_in;
            h1     <= hcount_in;
            v1     <= vcount_in;
            pix1   <= pixel_in;
            fill1  <= fill_mode_in;
            hit1   <= hit_now;
        end
    end

    // Lowest-index hit slot wins; colour or blend accordingly.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        pix_nxt = pix1;
        for (int i = 0; i < NUM_BOXES; i++) begin
            if (!found && hit1[i]) begin
                found = 1'b1;
                sel   = 3'(i);
            end
        end
        if (found) begin
            pix_nxt = fill1 ? blend565(pix1, PALETTE[sel]) : PALETTE[sel];
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            data_valid_out <= 1'b0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            pixel_out      <= '0;
        end else begin
            data_valid_out <= valid1;
            hcount_out     <= h1;
            vcount_out     <= v1;
            pixel_out      <= pix_nxt;
        end
    end

endmodule
`default_nettype wire
